// File: rtl/wb_burst_splitter_pkg.sv
// Shared constants and types for the Wishbone burst splitter:
// cycle-type/burst-type encodings and the FSM state enum.
package wb_burst_pkg;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR  = 2'b00;
    localparam logic [1:0] WRAP4   = 2'b01;
    localparam logic [1:0] WRAP8   = 2'b10;
    localparam logic [1:0] WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/wb_burst_splitter_if.sv
// Wishbone B4 bus bundle; the splitter takes a slave view (wbs_*) upstream
// and a master view (wbm_*) downstream. dat_w flows master->slave, dat_r back.
interface wb_burst_splitter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 28
);
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;
    logic [DATA_WIDTH-1:0]     dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, cti, bte,
        input  ack, err, rty, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, cti, bte,
        output ack, err, rty, dat_r
    );
endinterface

// File: rtl/wb_burst_splitter_addr_gen.sv
// Combinational next-beat address for Wishbone registered-feedback bursts:
// constant, linear, or wrap-4/8/16 on DATA_WIDTH/8-byte beats.
module wb_burst_addr_gen
    import wb_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 28
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            cti_i,
    input  logic [1:0]            bte_i,
    output logic [ADDR_WIDTH-1:0] next_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] inc_s;
    logic [ADDR_WIDTH-1:0] mask_s;

    // An all-ones mask turns the wrap formula into a plain linear increment.
    always_comb begin
        inc_s = addr_i + STEP;
        case (bte_i)
            LINEAR:  mask_s = '1;
            WRAP4:   mask_s = (STEP << 2) - ADDR_WIDTH'(1);
            WRAP8:   mask_s = (STEP << 3) - ADDR_WIDTH'(1);
            WRAP16:  mask_s = (STEP << 4) - ADDR_WIDTH'(1);
            default: mask_s = '1;
        endcase
        if (cti_i == CONST) begin
            next_o = addr_i;
        end else begin
            next_o = (addr_i & ~mask_s) | (inc_s & mask_s);
        end
    end

endmodule

// File: rtl/wb_burst_splitter.sv
// Replays Wishbone B4 burst beats as independent classic cycles downstream.
// Optional WB_BURST_SPLIT_CHECK_EN: reject non-first beats whose address differs from the predicted one.
module wb_burst_splitter
    import wb_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_burst_splitter_if.slave    wbs,
    wb_burst_splitter_if.master   wbm
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    burst_active_q, burst_active_d;
    logic [ADDR_WIDTH-1:0]   next_adr_q, next_adr_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [2:0]              cti_q, cti_d;
    logic [1:0]              bte_q, bte_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    mcyc_q, mcyc_d;
    logic [ADDR_WIDTH-1:0]   gen_next_s;
    logic                    resp_s;

    wb_burst_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i (adr_q),
        .cti_i  (cti_q),
        .bte_i  (bte_q),
        .next_o (gen_next_s)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d        = state_q;
        burst_active_d = burst_active_q;
        next_adr_d     = next_adr_q;
        adr_d          = adr_q;
        we_d           = we_q;
        dat_d          = dat_q;
        sel_d          = sel_q;
        cti_d          = cti_q;
        bte_d          = bte_q;
        rdata_d        = rdata_q;
        ack_d          = 1'b0;
        err_d          = 1'b0;
        mcyc_d         = 1'b0;
        resp_s         = wbm.ack | wbm.err | wbm.rty;

        case (state_q)
            IDLE: begin
                if (!wbs.cyc) begin
                    burst_active_d = 1'b0;
                end else if (wbs.stb) begin
                    we_d  = wbs.we;
                    dat_d = wbs.dat_w;
                    sel_d = wbs.sel;
                    cti_d = wbs.cti;
                    bte_d = wbs.bte;
                    adr_d = burst_active_q ? next_adr_q : wbs.adr;
`ifdef WB_BURST_SPLIT_CHECK_EN
                    if (burst_active_q && (wbs.adr != next_adr_q)) begin
                        err_d          = 1'b1;
                        burst_active_d = 1'b0;
                        state_d        = RESP;
                    end else begin
                        mcyc_d  = 1'b1;
                        state_d = REQ;
                    end
`else
                    mcyc_d  = 1'b1;
                    state_d = REQ;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // An abandoned beat still has to finish downstream; a response in the
                // same cycle as the abort is simply discarded.
                if (!wbs.cyc) begin
                    if (resp_s) begin
                        burst_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        mcyc_d  = 1'b1;
                        state_d = DRAIN;
                    end
                end else if (resp_s) begin
                    rdata_d = wbm.dat_r;
                    err_d   = wbm.err | wbm.rty;
                    ack_d   = ~(wbm.err | wbm.rty);
                    state_d = RESP;
                end else begin
                    mcyc_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (err_q) begin
                    burst_active_d = 1'b0;
                end else begin
                    burst_active_d = (cti_q == INCR) || (cti_q == CONST);
                    next_adr_d     = gen_next_s;
                end
            end
            DRAIN: begin
                if (resp_s) begin
                    burst_active_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    mcyc_d = 1'b1;
                end
            end
            default: begin
                burst_active_d = 1'b0;
                state_d        = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            burst_active_q <= 1'b0;
            next_adr_q     <= '0;
            adr_q          <= '0;
            we_q           <= 1'b0;
            dat_q          <= '0;
            sel_q          <= '0;
            cti_q          <= 3'b000;
            bte_q          <= 2'b00;
            rdata_q        <= '0;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            mcyc_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            burst_active_q <= burst_active_d;
            next_adr_q     <= next_adr_d;
            adr_q          <= adr_d;
            we_q           <= we_d;
            dat_q          <= dat_d;
            sel_q          <= sel_d;
            cti_q          <= cti_d;
            bte_q          <= bte_d;
            rdata_q        <= rdata_d;
            ack_q          <= ack_d;
            err_q          <= err_d;
            mcyc_q         <= mcyc_d;
        end
    end

    assign wbs.ack   = ack_q;
    assign wbs.err   = err_q;
    assign wbs.rty   = 1'b0;
    assign wbs.dat_r = rdata_q;

    assign wbm.cyc   = mcyc_q;
    assign wbm.stb   = mcyc_q;
    assign wbm.we    = we_q;
    assign wbm.adr   = adr_q;
    assign wbm.dat_w = dat_q;
    assign wbm.sel   = sel_q;
    assign wbm.cti   = 3'b000;
    assign wbm.bte   = 2'b00;

endmodule

// File: tb/tb_wb_burst_splitter.sv
// Directed bench for wb_burst_splitter: classic, wrap, linear-rollover, error,
// abort/drain and address-check scenarios with hand-computed expectations.
module tb_wb_burst_splitter;
    import wb_burst_pkg::*;

    localparam int DW = 32;
    localparam int AW = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_burst_splitter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) up ();
    wb_burst_splitter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dn ();

    wb_burst_splitter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wbs (up),
        .wbm (dn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        up.cyc = 1'b0;
        up.stb = 1'b0;
        step();
    endtask

    // resp: 0 ack, 1 err, 2 rty, 3 ack+err together
    task automatic beat(input string tag, input logic [27:0] adr, input logic we,
                        input logic [31:0] wdat, input logic [3:0] sel,
                        input logic [2:0] cti, input logic [1:0] bte,
                        input int waits, input int resp, input logic [31:0] rdat,
                        input logic [27:0] exp_madr);
        up.cyc = 1'b1; up.stb = 1'b1; up.we = we; up.adr = adr;
        up.dat_w = wdat; up.sel = sel; up.cti = cti; up.bte = bte;
        step();
        check({tag, " mcyc"}, 32'(dn.cyc), 32'd1);
        check({tag, " mstb"}, 32'(dn.stb), 32'd1);
        check({tag, " madr"}, 32'(dn.adr), 32'(exp_madr));
        check({tag, " mwe"},  32'(dn.we),  32'(we));
        check({tag, " msel"}, 32'(dn.sel), 32'(sel));
        check({tag, " mcti"}, 32'(dn.cti), 32'd0);
        if (we) check({tag, " mdat"}, dn.dat_w, wdat);
        for (int i = 0; i < waits; i++) begin
            step();
            check({tag, " hold stb"}, 32'(dn.stb), 32'd1);
            check({tag, " hold adr"}, 32'(dn.adr), 32'(exp_madr));
            check({tag, " early ack"}, 32'(up.ack | up.err), 32'd0);
        end
        dn.ack   = (resp == 0) || (resp == 3);
        dn.err   = (resp == 1) || (resp == 3);
        dn.rty   = (resp == 2);
        dn.dat_r = rdat;
        step();
        dn.ack = 1'b0; dn.err = 1'b0; dn.rty = 1'b0; dn.dat_r = 32'hA5A5_A5A5;
        check({tag, " mcyc drop"}, 32'(dn.cyc), 32'd0);
        check({tag, " sack"}, 32'(up.ack), 32'(resp == 0));
        check({tag, " serr"}, 32'(up.err), 32'(resp != 0));
        check({tag, " srty"}, 32'(up.rty), 32'd0);
        if (!we) check({tag, " sdat"}, up.dat_r, rdat);
        step();
        check({tag, " one-cycle"}, 32'(up.ack | up.err), 32'd0);
    endtask

    initial begin
        up.cyc = 1'b0; up.stb = 1'b0; up.we = 1'b0; up.adr = '0; up.dat_w = '0;
        up.sel = '0; up.cti = 3'b000; up.bte = 2'b00;
        dn.ack = 1'b0; dn.err = 1'b0; dn.rty = 1'b0; dn.dat_r = '0;

        step();
        step();
        check("rst wbs_ack", 32'(up.ack), 32'd0);
        check("rst wbs_err", 32'(up.err), 32'd0);
        check("rst wbs_dat", up.dat_r, 32'd0);
        check("rst wbm_cyc", 32'(dn.cyc), 32'd0);
        check("rst wbm_adr", 32'(dn.adr), 32'd0);
        check("rst wbm_sel", 32'(dn.sel), 32'd0);
        check("rst wbm_we",  32'(dn.we),  32'd0);
        check("rst state",   32'(dut.state_q), 32'(IDLE));
        check("rst burst",   32'(dut.burst_active_q), 32'd0);
        check("rst next",    32'(dut.next_adr_q), 32'd0);
        rst = 1'b0;
        step();

        // Classic read, downstream acks two cycles after strobe
        beat("classic", 28'h100, 1'b0, 32'h0, 4'hF, CLASSIC, LINEAR, 2, 0, 32'hDEAD_BEEF, 28'h100);
        bus_idle();

        // Wrap-4 read from 0x108
        beat("wrap0", 28'h108, 1'b0, 32'h0, 4'hF, INCR, WRAP4, 0, 0, 32'h0000_0001, 28'h108);
        check("wrap burst set", 32'(dut.burst_active_q), 32'd1);
        beat("wrap1", 28'h10C, 1'b0, 32'h0, 4'hF, INCR, WRAP4, 0, 0, 32'h0000_0002, 28'h10C);
        beat("wrap2", 28'h100, 1'b0, 32'h0, 4'hF, INCR, WRAP4, 1, 0, 32'h0000_0003, 28'h100);
        beat("wrap3", 28'h104, 1'b0, 32'h0, 4'hF, EOB,  WRAP4, 0, 0, 32'h0000_0004, 28'h104);
        check("wrap burst clr", 32'(dut.burst_active_q), 32'd0);
        bus_idle();

        // Linear write burst rolling over the top of the address space
        beat("lin0", 28'hFFFFFFC, 1'b1, 32'h1111_1111, 4'hF, INCR, LINEAR, 0, 0, 32'h0, 28'hFFFFFFC);
        beat("lin1", 28'h0000000, 1'b1, 32'h2222_2222, 4'hF, EOB,  LINEAR, 0, 0, 32'h0, 28'h0000000);
        bus_idle();

        // Incrementing read with an error on beat 2, then a fresh start
        beat("err0", 28'h200, 1'b0, 32'h0, 4'hF, INCR, LINEAR, 0, 0, 32'hCAFE_0001, 28'h200);
        beat("err1", 28'h204, 1'b0, 32'h0, 4'hF, INCR, LINEAR, 0, 1, 32'hCAFE_0002, 28'h204);
        check("err burst clr", 32'(dut.burst_active_q), 32'd0);
        beat("err2", 28'h400, 1'b0, 32'h0, 4'h3, CLASSIC, LINEAR, 0, 0, 32'hCAFE_0003, 28'h400);
        bus_idle();

        // Retry and simultaneous ack+err both surface as slave err
        beat("rty", 28'h700, 1'b0, 32'h0, 4'hF, CLASSIC, LINEAR, 1, 2, 32'h7777_0000, 28'h700);
        beat("ackerr", 28'h704, 1'b0, 32'h0, 4'hF, CLASSIC, LINEAR, 0, 3, 32'h7777_0004, 28'h704);
        bus_idle();

        // Constant-address burst repeats the same address
        beat("const0", 28'h600, 1'b1, 32'hABCD_0001, 4'h1, CONST, LINEAR, 0, 0, 32'h0, 28'h600);
        beat("const1", 28'h600, 1'b1, 32'hABCD_0002, 4'h2, EOB,   LINEAR, 0, 0, 32'h0, 28'h600);
        bus_idle();

        // Abort during REQ: master cycle held until the downstream response
        up.cyc = 1'b1; up.stb = 1'b1; up.we = 1'b0; up.adr = 28'h500;
        up.cti = CLASSIC; up.bte = LINEAR; up.sel = 4'hF;
        step();
        check("drain req cyc", 32'(dn.cyc), 32'd1);
        up.cyc = 1'b0; up.stb = 1'b0;
        step();
        check("drain cyc held", 32'(dn.cyc), 32'd1);
        check("drain stb held", 32'(dn.stb), 32'd1);
        check("drain adr", 32'(dn.adr), 32'h500);
        check("drain no ack", 32'(up.ack | up.err), 32'd0);
        step();
        check("drain stb held2", 32'(dn.stb), 32'd1);
        dn.ack = 1'b1; dn.dat_r = 32'h1234_5678;
        step();
        dn.ack = 1'b0;
        check("drain cyc drop", 32'(dn.cyc), 32'd0);
        check("drain no sack", 32'(up.ack | up.err), 32'd0);
        check("drain state", 32'(dut.state_q), 32'(IDLE));
        step();
        check("drain quiet", 32'(up.ack | up.err | dn.cyc), 32'd0);

        // Non-first beat presenting an unexpected address
        beat("chk0", 28'h100, 1'b0, 32'h0, 4'hF, INCR, LINEAR, 0, 0, 32'h0000_0100, 28'h100);
`ifdef WB_BURST_SPLIT_CHECK_EN
        up.cyc = 1'b1; up.stb = 1'b1; up.adr = 28'h300; up.cti = EOB;
        step();
        check("chk no mstb", 32'(dn.stb), 32'd0);
        check("chk serr", 32'(up.err), 32'd1);
        check("chk no sack", 32'(up.ack), 32'd0);
        step();
        check("chk err one-cycle", 32'(up.err), 32'd0);
        check("chk burst clr", 32'(dut.burst_active_q), 32'd0);
`else
        beat("chk1", 28'h300, 1'b0, 32'h0, 4'hF, EOB, LINEAR, 0, 0, 32'h0000_0104, 28'h104);
`endif
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_burst_splitter.md
Name: wb_burst_splitter

Overview:
- Sits directly upstream of the Wishbone-to-AXI bridge, which only issues single-beat AXI transfers (len 0).
- Accepts Wishbone B4 registered-feedback bursts (cti/bte) from the CPU/data master.
- Replays each burst beat as an independent classic Wishbone cycle on its master port, generating linear or wrapping beat addresses internally.
- Registers responses back to the requesting master.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; beat step = DATA_WIDTH/8 bytes.
- ADDR_WIDTH, 28, byte address width on both sides.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wbs_cyc_i  in  1  slave cycle
- wbs_stb_i  in  1  slave strobe
- wbs_we_i  in  1  write enable
- wbs_adr_i  in  ADDR_WIDTH  byte address
- wbs_dat_i  in  DATA_WIDTH  write data
- wbs_sel_i  in  DATA_WIDTH/8  byte selects
- wbs_cti_i  in  3  cycle type
- wbs_bte_i  in  2  burst type
- wbs_ack_o  out  1  beat acknowledge
- wbs_err_o  out  1  beat error
- wbs_rty_o  out  1  tied 0
- wbs_dat_o  out  DATA_WIDTH  read data
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  master classic cycle
- wbm_adr_o  out  ADDR_WIDTH  beat address
- wbm_dat_o  out  DATA_WIDTH  beat write data
- wbm_sel_o  out  DATA_WIDTH/8  beat selects
- wbm_cti_o  out  3  constant 3'b000
- wbm_bte_o  out  2  constant 2'b00
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  master responses
- wbm_dat_i  in  DATA_WIDTH  master read data

Behaviour:
- Reset: every registered output is 0. State is IDLE, burst_active=0, next_adr=0.
- FSM states: IDLE, REQ, RESP, DRAIN.
- IDLE:
  - Starts a beat on wbs_cyc_i&wbs_stb_i.
  - Latches we, dat, sel, cti, bte.
  - Beat address = next_adr if burst_active, else wbs_adr_i.
  - Goes to REQ.
- REQ:
  - wbm_cyc_o=wbm_stb_o=1; wbm_adr/dat/sel/we come from the latched values and are held stable.
  - On wbm_ack_i, wbm_err_i or wbm_rty_i: capture wbm_dat_i into wbs_dat_o and go to RESP.
  - If wbs_cyc_i falls while in REQ: go to DRAIN.
- DRAIN:
  - Keeps the master cycle asserted until a response arrives; the downstream AXI transaction cannot be aborted.
  - Discards the response, clears burst_active, returns to IDLE.
  - No slave ack or err is issued.
- RESP:
  - wbs_ack_o=1 for exactly one cycle on ack; wbs_err_o=1 for exactly one cycle on err or rty.
  - The master cycle is deasserted in this cycle.
  - Updates next_adr and burst_active, then returns to IDLE.
- Burst tracking:
  - burst_active is set after an acked beat with latched cti 010 (incrementing) or 001 (constant).
  - burst_active is cleared on cti 000 or 111, on any err/rty, or when wbs_cyc_i is low in IDLE.
- Next-address arithmetic (step S = DATA_WIDTH/8):
  - cti 001: next = addr.
  - bte 00 (linear): next = (addr+S) mod 2^ADDR_WIDTH.
  - bte 01/10/11 (wrap 4/8/16 beats): mask = N*S-1; next = (addr & ~mask) | ((addr+S) & mask).
- Latency: slave strobe at cycle 0 → master strobe at cycle 1. Master response at cycle k → slave ack at k+1. Minimum 3 cycles per beat.
- Simultaneous ack and err from the master: err wins.

Optional Feature:
- Macro: WB_BURST_SPLIT_CHECK_EN.
- Defined: in IDLE with burst_active, wbs_adr_i is compared to next_adr. On mismatch, no master cycle is issued; go to RESP with wbs_err_o=1 and clear burst_active.
- Undefined: wbs_adr_i is ignored on non-first beats.

Decomposition:
- Package wb_burst_pkg holds:
  - CTI constants CLASSIC, CONST, INCR, EOB.
  - BTE constants LINEAR, WRAP4, WRAP8, WRAP16.
  - FSM state enum.
- Sub-module wb_burst_addr_gen: purely combinational next-address calculator. Inputs addr, cti, bte; output next.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=28):
- Classic read at 0x100, master acks 2 cycles after strobe with 0xDEADBEEF → one master cycle at 0x100; wbs_ack_o and wbs_dat_o=0xDEADBEEF one cycle after wbm_ack_i.
- Wrap-4 read burst from 0x108 (cti 010 ×3, then 111) → master addresses 0x108, 0x10C, 0x100, 0x104; 4 slave acks; burst_active=0 afterwards.
- Linear write burst from 0xFFFFFFC, 2 beats, data 0x11111111 and 0x22222222 → master writes 0xFFFFFFC then 0x0000000, each with the matching data and sel=0xF.
- Incrementing read from 0x200 with wbm_err_i on beat 2 → wbs_err_o on beat 2. A new beat then presenting wbs_adr_i=0x400 starts at 0x400.
- wbs_cyc_i dropped while in REQ → master strobe held until wbm_ack_i; no wbs_ack_o or wbs_err_o; FSM returns to IDLE.
- With WB_BURST_SPLIT_CHECK_EN defined, second beat presenting 0x300 when 0x104 is expected → wbs_err_o, no master strobe. Without the macro → master cycle issued at 0x104.
